// File: rtl/spi_frame_loader_pkg.sv
// Shared definitions for the SPI pixel frame loader: command bytes, FSM states
// and pixel geometry. Optional bank swapping is enabled with SPI_FRAME_LOADER_BANK_EN.
package spi_frame_loader_pkg;

  localparam logic [7:0] CMD_FRAME = 8'h01;
  localparam logic [7:0] CMD_ADDR  = 8'h02;
  localparam logic [7:0] CMD_SWAP  = 8'h03;

  localparam int PIXEL_BYTES = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_PIX_HI,
    ST_PIX_LO,
    ST_DISCARD
  } state_t;

endpackage

// File: rtl/spi_frame_loader_byte_rx.sv
// SPI mode-0 byte receiver, oversampled in the system clock domain: input
// synchronizers, SCK rising-edge detect and MSB-first byte assembly.
module spi_byte_rx
  import spi_frame_loader_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_spi_sck,
  input  logic       i_spi_cs_n,
  input  logic       i_spi_mosi,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_cs_active
);

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sck_prev;
  logic [2:0]             r_bit_cnt;
  logic [6:0]             r_shift;

  logic w_sck;
  logic w_cs_n;
  logic w_mosi;
  logic w_rise;

  assign w_sck  = r_sck_sync[SYNC_STAGES-1];
  assign w_cs_n = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];
  assign w_rise = w_sck & ~r_sck_prev;

  // Synchronizers come out of reset at the bus idle levels so no false edge is seen.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sck_sync  <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sck_prev  <= 1'b0;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], i_spi_sck};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_spi_cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
      r_sck_prev  <= w_sck;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_bit_cnt <= 3'd0;
      r_shift   <= 7'd0;
    end else if (w_cs_n) begin
      r_bit_cnt <= 3'd0;
    end else if (w_rise) begin
      r_bit_cnt <= r_bit_cnt + 3'd1;
      r_shift   <= {r_shift[5:0], w_mosi};
    end
  end

  // The eighth bit is taken straight from the synchronizer, so the byte is
  // presented in the same cycle as the completing edge.
  assign o_byte       = {r_shift, w_mosi};
  assign o_byte_valid = w_rise & ~w_cs_n & (r_bit_cnt == 3'd7);
  assign o_cs_active  = ~w_cs_n;

endmodule

// File: rtl/spi_frame_loader.sv
// SPI command decoder that assembles 16-bit pixels and writes them into the
// pixel RAM. Define SPI_FRAME_LOADER_BANK_EN for double-buffered bank swapping.
module spi_frame_loader
  import spi_frame_loader_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_spi_sck,
  input  logic              i_spi_cs_n,
  input  logic              i_spi_mosi,
`ifdef SPI_FRAME_LOADER_BANK_EN
  output logic [ADDR_W:0]   o_w_addr,
`else
  output logic [ADDR_W-1:0] o_w_addr,
`endif
  output logic [DATA_W-1:0] o_w_data,
  output logic              o_w_enable,
  output logic              o_busy,
  output logic              o_frame_done
`ifdef SPI_FRAME_LOADER_BANK_EN
  ,
  output logic              o_bank
`endif
);

  logic [7:0] w_byte;
  logic       w_byte_valid;
  logic       w_cs_active;

  spi_byte_rx #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_byte_rx (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_spi_sck    (i_spi_sck),
    .i_spi_cs_n   (i_spi_cs_n),
    .i_spi_mosi   (i_spi_mosi),
    .o_byte       (w_byte),
    .o_byte_valid (w_byte_valid),
    .o_cs_active  (w_cs_active)
  );

  state_t                       r_state;
  state_t                       w_next_state;
  logic [ADDR_W-1:0]            r_ptr;
  logic [ADDR_W-9:0]            r_addr_hi;
  logic [7:0]                   r_pix_hi;
  logic [ADDR_W-1:0]            r_w_addr;
  logic [DATA_W-1:0]            r_w_data;
  logic                         r_w_enable;
  logic                         r_frame_done;
  logic [PIXEL_BYTES*8-1:0]     w_pixel;

  logic w_ptr_zero;
  logic w_ptr_load;
  logic w_cap_addr;
  logic w_cap_pix;
  logic w_write;
`ifdef SPI_FRAME_LOADER_BANK_EN
  logic w_swap;
  logic r_bank;
  logic r_w_addr_msb;
`endif

  assign w_pixel = {r_pix_hi, w_byte};

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_next_state;
  end

  // A deasserted chip select overrides everything, including a byte that
  // completes in the same cycle, so half pixels never reach the RAM.
  always_comb begin
    w_next_state = r_state;
    w_ptr_zero   = 1'b0;
    w_ptr_load   = 1'b0;
    w_cap_addr   = 1'b0;
    w_cap_pix    = 1'b0;
    w_write      = 1'b0;
`ifdef SPI_FRAME_LOADER_BANK_EN
    w_swap       = 1'b0;
`endif
    if (!w_cs_active) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: w_next_state = ST_CMD;
        ST_CMD: begin
          if (w_byte_valid) begin
            if (w_byte == CMD_FRAME) begin
              w_ptr_zero   = 1'b1;
              w_next_state = ST_PIX_HI;
            end else if (w_byte == CMD_ADDR) begin
              w_next_state = ST_ADDR_HI;
`ifdef SPI_FRAME_LOADER_BANK_EN
            end else if (w_byte == CMD_SWAP) begin
              w_swap       = 1'b1;
              w_next_state = ST_DISCARD;
`endif
            end else begin
              w_next_state = ST_DISCARD;
            end
          end
        end
        ST_ADDR_HI: begin
          if (w_byte_valid) begin
            w_cap_addr   = 1'b1;
            w_next_state = ST_ADDR_LO;
          end
        end
        ST_ADDR_LO: begin
          if (w_byte_valid) begin
            w_ptr_load   = 1'b1;
            w_next_state = ST_PIX_HI;
          end
        end
        ST_PIX_HI: begin
          if (w_byte_valid) begin
            w_cap_pix    = 1'b1;
            w_next_state = ST_PIX_LO;
          end
        end
        ST_PIX_LO: begin
          if (w_byte_valid) begin
            w_write      = 1'b1;
            w_next_state = ST_PIX_HI;
          end
        end
        ST_DISCARD: w_next_state = ST_DISCARD;
        default:    w_next_state = ST_IDLE;
      endcase
    end
  end

  // Only the low ADDR_W bits of the big-endian address are kept, so just the
  // needed bits of the high byte are stored.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ptr        <= '0;
      r_addr_hi    <= '0;
      r_pix_hi     <= 8'd0;
      r_w_addr     <= '0;
      r_w_data     <= '0;
      r_w_enable   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_w_enable   <= w_write;
      r_frame_done <= w_write && (r_ptr == '1);
      if (w_ptr_zero)      r_ptr <= '0;
      else if (w_ptr_load) r_ptr <= {r_addr_hi, w_byte};
      else if (w_write)    r_ptr <= r_ptr + ADDR_W'(1);
      if (w_cap_addr) r_addr_hi <= w_byte[ADDR_W-9:0];
      if (w_cap_pix)  r_pix_hi  <= w_byte;
      if (w_write) begin
        r_w_addr <= r_ptr;
        r_w_data <= w_pixel[DATA_W-1:0];
      end
    end
  end

`ifdef SPI_FRAME_LOADER_BANK_EN
  // Writes target the hidden bank; the MSB is captured with each write so
  // the address bus stays stable (and zero out of reset) between writes.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_bank       <= 1'b0;
      r_w_addr_msb <= 1'b0;
    end else begin
      if (w_swap)  r_bank       <= ~r_bank;
      if (w_write) r_w_addr_msb <= ~r_bank;
    end
  end

  assign o_w_addr = {r_w_addr_msb, r_w_addr};
  assign o_bank   = r_bank;
`else
  assign o_w_addr = r_w_addr;
`endif

  assign o_w_data     = r_w_data;
  assign o_w_enable   = r_w_enable;
  assign o_frame_done = r_frame_done;
  assign o_busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_spi_frame_loader.sv
// Directed plus randomized bench for spi_frame_loader with a transaction-level
// reference model of the command protocol.
module tb_spi_frame_loader;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
`ifdef SPI_FRAME_LOADER_BANK_EN
  localparam int AW_OUT = ADDR_W + 1;
`else
  localparam int AW_OUT = ADDR_W;
`endif
  localparam int W = 1 + AW_OUT + DATA_W;

  // clock / reset
  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic sck  = 1'b0;
  logic cs_n = 1'b1;
  logic mosi = 1'b0;

  always #10 clk = ~clk;

  logic [AW_OUT-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              w_en;
  logic              busy;
  logic              fdone;
`ifdef SPI_FRAME_LOADER_BANK_EN
  logic              bank;
`endif

  spi_frame_loader #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .SYNC_STAGES (2)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_spi_sck    (sck),
    .i_spi_cs_n   (cs_n),
    .i_spi_mosi   (mosi),
    .o_w_addr     (w_addr),
    .o_w_data     (w_data),
    .o_w_enable   (w_en),
    .o_busy       (busy),
    .o_frame_done (fdone)
`ifdef SPI_FRAME_LOADER_BANK_EN
    ,
    .o_bank       (bank)
`endif
  );

  // scoreboard state
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  logic [7:0]   tx_q[$];
  int   m_ptr  = 0;
  logic m_bank = 1'b0;

  always @(negedge clk) begin
    if (w_en) obs_q.push_back({fdone, w_addr, w_data});
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Reference model: interpret the byte list of one complete transaction.
  task automatic model_txn();
    int idx;
    logic [AW_OUT-1:0] a;
    logic [DATA_W-1:0] d;
    if (tx_q.size() == 0) return;
    idx = 1;
    if (tx_q[0] == 8'h01) begin
      m_ptr = 0;
    end else if (tx_q[0] == 8'h02) begin
      if (tx_q.size() < 3) return;
      m_ptr = (int'(tx_q[1]) * 256 + int'(tx_q[2])) % (1 << ADDR_W);
      idx = 3;
`ifdef SPI_FRAME_LOADER_BANK_EN
    end else if (tx_q[0] == 8'h03) begin
      m_bank = ~m_bank;
      return;
`endif
    end else begin
      return;
    end
    while (idx + 1 < tx_q.size()) begin
`ifdef SPI_FRAME_LOADER_BANK_EN
      a = {~m_bank, ADDR_W'(m_ptr)};
`else
      a = ADDR_W'(m_ptr);
`endif
      d = {tx_q[idx], tx_q[idx+1]};
      exp_q.push_back({(m_ptr == (1 << ADDR_W) - 1), a, d});
      m_ptr = (m_ptr + 1) % (1 << ADDR_W);
      idx += 2;
    end
  endtask

  // drivers
  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      mosi = b[i];
      repeat (4) @(negedge clk);
      sck = 1'b1;
      repeat (4) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic wait_idle(input string tag);
    int c;
    c = 0;
    while (busy && c < 20) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_idle"}, W'(busy), W'(0));
    repeat (2) @(negedge clk);
  endtask

  task automatic compare_writes(input string tag);
    logic [W-1:0] o;
    logic [W-1:0] e;
    logic [W-1:0] last_e;
    logic had;
    had = 1'b0;
    last_e = '0;
    check({tag, "_count"}, W'(obs_q.size()), W'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_write"}, o, e);
      last_e = e;
      had = 1'b1;
    end
    if (had) check({tag, "_hold"}, {1'b0, w_addr, w_data}, {1'b0, last_e[W-2:0]});
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic run_txn(input string tag);
    model_txn();
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    foreach (tx_q[k]) send_byte(tx_q[k]);
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    @(negedge clk);
    check({tag, "_busy_after_cs"}, W'(busy), W'(1));
    wait_idle(tag);
    compare_writes(tag);
    tx_q.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_en"},    W'(w_en),   W'(0));
    check({tag, "_addr"},  W'(w_addr), W'(0));
    check({tag, "_data"},  W'(w_data), W'(0));
    check({tag, "_busy"},  W'(busy),   W'(0));
    check({tag, "_fdone"}, W'(fdone),  W'(0));
`ifdef SPI_FRAME_LOADER_BANK_EN
    check({tag, "_bank"},  W'(bank),   W'(0));
`endif
  endtask

  initial begin
    logic [7:0] b;
    int r;
    int nb;

    // reset
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // frame command, two pixels
    tx_q = '{8'h01, 8'hF8, 8'h00, 8'h07, 8'hE0};
    run_txn("frame2");

    // address command near the wrap point
    tx_q = '{8'h02, 8'h0F, 8'hFE, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04};
    run_txn("addr_wrap");

    // half pixel aborted by CS, then a clean pixel
    tx_q = '{8'h01, 8'hAB};
    run_txn("half_pixel");
    tx_q = '{8'h01, 8'h12, 8'h34};
    run_txn("after_abort");

    // unknown command followed by ten bytes
    tx_q.push_back(8'h55);
    for (int i = 0; i < 10; i++) tx_q.push_back(8'($urandom_range(0, 255)));
    run_txn("unknown_cmd");

    // reset between the two pixel bytes
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    send_byte(8'h01);
    send_byte(8'hAB);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_outputs_zero("mid_reset");
    cs_n = 1'b1;
    m_bank = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_reset_nowrite", W'(obs_q.size()), W'(0));
    obs_q.delete();
    tx_q = '{8'h01, 8'hBE, 8'hEF};
    run_txn("post_reset");

`ifdef SPI_FRAME_LOADER_BANK_EN
    tx_q = '{8'h01, 8'h11, 8'h22};
    run_txn("bank0_write");
    tx_q = '{8'h03};
    run_txn("bank_swap");
    check("bank_after_swap", W'(bank), W'(m_bank));
    tx_q = '{8'h01, 8'h33, 8'h44};
    run_txn("bank1_write");
`endif

    // randomized transactions
    for (int t = 0; t < 8; t++) begin
      r = $urandom_range(0, 3);
      case (r)
        0: tx_q.push_back(8'h01);
        1: begin
          tx_q.push_back(8'h02);
          tx_q.push_back(8'($urandom_range(0, 255)));
          tx_q.push_back(8'($urandom_range(250, 255)));
        end
        2: tx_q.push_back(8'h03);
        default: begin
          b = 8'($urandom_range(4, 255));
          tx_q.push_back(b);
        end
      endcase
      nb = $urandom_range(0, 5);
      for (int i = 0; i < nb; i++) tx_q.push_back(8'($urandom_range(0, 255)));
      run_txn("random");
`ifdef SPI_FRAME_LOADER_BANK_EN
      check("random_bank", W'(bank), W'(m_bank));
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
